// File: rtl/sram_cim_array.sv
// Bit-serial SRAM compute-in-memory macro: DEPTH x WIDTH binary weights, IN_BITS-bit activations.
// Define SRAM_CIM_RELU_EN to clamp negative signed results to zero on read-back.
module sram_cim_array #(
    parameter int DEPTH   = 64,
    parameter int WIDTH   = 16,
    parameter int IN_BITS = 4,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a,
    input  logic [WIDTH-1:0]  d,
    input  logic              wrt,
    input  logic              wrtbuf,
    input  logic              comp,
    input  logic              model,
    input  logic              wait_,
    input  logic              set,
    input  logic              read,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              done
);
    localparam int ACC_W = $clog2(DEPTH + 1) + IN_BITS + 1;
    localparam int CNT_W = $clog2(IN_BITS);
    localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(IN_BITS - 1);

    if (ACC_W > WIDTH) begin : g_bad_acc_w
        $error("sram_cim_array: accumulator width exceeds WIDTH");
    end
    if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
        $error("sram_cim_array: ADDR_W must equal clog2(DEPTH)");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_model;
    logic [WIDTH-1:0]         r_q;
    logic                     r_busy;
    logic                     r_done;
    logic signed [ACC_W-1:0]  r_acc    [WIDTH];
    logic [WIDTH-1:0]         r_weight [DEPTH];
    logic [IN_BITS-1:0]       r_act    [DEPTH];

    logic [ACC_W-1:0]         w_pc [WIDTH];
    logic signed [ACC_W-1:0]  w_rd_acc;
    logic [WIDTH-1:0]         w_rd_q;

    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;

    // NOTE: the storage arrays have no reset; clearing thousands of bitcells is not something the macro does.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            if (wrt)
                r_weight[a] <= d;
            if (wrtbuf)
                r_act[a] <= d[IN_BITS-1:0];
        end
    end

    // Column popcount of the current activation bit-plane against the weight bits.
    always_comb begin
        for (int c = 0; c < WIDTH; c++) begin
            w_pc[c] = '0;
            for (int r = 0; r < DEPTH; r++)
                w_pc[c] = w_pc[c] + ACC_W'(r_act[r][r_cnt] & r_weight[r][c]);
        end
    end

    always_comb begin
        w_rd_acc = '0;
        for (int c = 0; c < WIDTH; c++)
            if (a == ADDR_W'(c))
                w_rd_acc = r_acc[c];
        if (r_model)
            w_rd_q = WIDTH'(w_rd_acc);
        else
            w_rd_q = WIDTH'($unsigned(w_rd_acc));
`ifdef SRAM_CIM_RELU_EN
        if (r_model && w_rd_acc[ACC_W-1])
            w_rd_q = '0;
`endif
    end

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_model <= 1'b0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int c = 0; c < WIDTH; c++)
                r_acc[c] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (comp) begin
                        r_model <= model;
                        r_cnt   <= CNT_MSB;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                        for (int c = 0; c < WIDTH; c++)
                            r_acc[c] <= '0;
                    end else if (set) begin
                        for (int c = 0; c < WIDTH; c++)
                            r_acc[c] <= '0;
                    end
                    if (read)
                        r_q <= w_rd_q;
                end
                S_RUN: begin
                    if (!wait_) begin
                        // The MSB plane carries negative weight in two's-complement mode.
                        for (int c = 0; c < WIDTH; c++) begin
                            if (r_model && (r_cnt == CNT_MSB))
                                r_acc[c] <= (r_acc[c] <<< 1) - $signed(w_pc[c]);
                            else
                                r_acc[c] <= (r_acc[c] <<< 1) + $signed(w_pc[c]);
                        end
                        if (r_cnt == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_cim_array.sv
// Self-checking bench for sram_cim_array: directed and random runs against an arithmetic dot-product model.
module tb_sram_cim_array;
    localparam int DEPTH   = 64;
    localparam int WIDTH   = 16;
    localparam int IN_BITS = 4;
    localparam int ADDR_W  = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  d;
    logic              wrt, wrtbuf, comp, model, wait_, set, read;
    logic [WIDTH-1:0]  q;
    logic              busy, done;

    sram_cim_array #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IN_BITS(IN_BITS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .d(d), .wrt(wrt), .wrtbuf(wrtbuf), .comp(comp),
        .model(model), .wait_(wait_), .set(set), .read(read), .q(q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference state: weights, activations, and the expected per-channel dot products.
    logic [WIDTH-1:0]   m_w   [DEPTH];
    logic [IN_BITS-1:0] m_act [DEPTH];
    int                 m_acc [WIDTH];
    bit                 m_model;
    int                 checks = 0;
    int                 errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int act_val(input int r);
        if (m_model)
            return int'($signed(m_act[r]));
        return int'(m_act[r]);
    endfunction

    function automatic void model_compute();
        for (int c = 0; c < WIDTH; c++) begin
            m_acc[c] = 0;
            for (int r = 0; r < DEPTH; r++)
                if (m_w[r][c])
                    m_acc[c] += act_val(r);
        end
    endfunction

    function automatic logic [WIDTH-1:0] exp_q(input int ch);
        int v;
        if (ch >= WIDTH)
            return '0;
        v = m_acc[ch];
`ifdef SRAM_CIM_RELU_EN
        if (m_model && v < 0)
            v = 0;
`endif
        return WIDTH'(v);
    endfunction

    task automatic write_w(input int r, input logic [WIDTH-1:0] w);
        a = ADDR_W'(r); d = w; wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
        m_w[r] = w;
    endtask

    task automatic write_act(input int r, input logic [IN_BITS-1:0] v);
        a = ADDR_W'(r); d = WIDTH'(v); wrtbuf = 1'b1;
        @(negedge clk);
        wrtbuf = 1'b0;
        m_act[r] = v;
    endtask

    task automatic read_ch(input int ch, output logic [WIDTH-1:0] q_o);
        a = ADDR_W'(ch); read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        q_o = q;
    endtask

    task automatic read_all(input string tag);
        logic [WIDTH-1:0] qv;
        for (int ch = 0; ch < WIDTH; ch++) begin
            read_ch(ch, qv);
            check($sformatf("%s_ch%0d", tag, ch), 32'(qv), 32'(exp_q(ch)));
        end
    endtask

    // Starts a computation; optionally stalls and pokes every control input while busy.
    task automatic run_comp(input bit m, input int stall_at, input int stall_len, input bit poke,
                            output int lat);
        model = m; comp = 1'b1;
        @(negedge clk);
        comp = 1'b0;
        lat = 0;
        check("busy_after_comp", 32'(busy), 32'd1);
        while (done !== 1'b1 && lat < 100) begin
            wait_ = (lat >= stall_at && lat < stall_at + stall_len);
            if (poke && lat == 1) begin
                a = '0; d = 16'h1234;
                {wrt, wrtbuf, comp, set, read} = 5'b11111;
            end else begin
                {wrt, wrtbuf, comp, set, read} = 5'b00000;
            end
            @(negedge clk);
            lat++;
        end
        wait_ = 1'b0;
        {wrt, wrtbuf, comp, set, read} = 5'b00000;
        check("latency", 32'(lat), 32'(IN_BITS + stall_len));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_cleared", 32'(busy), 32'd0);
        m_model = m;
        model_compute();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat0, lat1;
        logic [WIDTH-1:0] qv, q_hold;
        bit seen_done;

        rst_n = 1'b0;
        a = '0; d = '0;
        {wrt, wrtbuf, comp, model, wait_, set, read} = 7'b0;
        m_model = 1'b0;
        for (int c = 0; c < WIDTH; c++) m_acc[c] = 0;
        repeat (3) @(negedge clk);
        check("reset_q", 32'(q), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < DEPTH; r++) begin
            write_w(r, '0);
            write_act(r, '0);
        end

        // Unsigned, single active row.
        write_w(0, 16'hFFFF);
        write_act(0, 4'd5);
        run_comp(1'b0, 0, 0, 1'b0, lat0);
        read_all("unsigned_row0");
        read_ch(7, qv);
        check("unsigned_const", 32'(qv), 32'h0005);

        // Signed, MSB plane subtracts.
        write_act(0, 4'b1011);
        run_comp(1'b1, 0, 0, 1'b0, lat0);
        read_ch(3, qv);
`ifdef SRAM_CIM_RELU_EN
        check("signed_relu_ch3", 32'(qv), 32'h0000);
`else
        check("signed_ch3", 32'(qv), 32'hFFFB);
`endif
        read_all("signed_row0");

        // Full scale, then column masking.
        for (int r = 0; r < DEPTH; r++) begin
            write_w(r, 16'hFFFF);
            write_act(r, 4'hF);
        end
        run_comp(1'b0, 0, 0, 1'b0, lat0);
        read_ch(15, qv);
        check("full_scale_const", 32'(qv), 32'h03C0);
        read_all("full_scale");
        for (int r = 0; r < DEPTH; r++) write_w(r, 16'h0001);
        run_comp(1'b0, 0, 0, 1'b0, lat0);
        read_all("col_mask");

        // Random contents and mode.
        for (int it = 0; it < 3; it++) begin
            for (int r = 0; r < DEPTH; r++) begin
                write_w(r, WIDTH'($urandom));
                write_act(r, IN_BITS'($urandom));
            end
            run_comp(1'($urandom), 0, 0, 1'b0, lat0);
            read_all($sformatf("rand%0d", it));
            read_ch(WIDTH + int'($urandom_range(0, 2**ADDR_W - WIDTH - 1)), qv);
            check("rand_out_of_range", 32'(qv), 32'd0);
        end

        // Stall and busy-time pokes.
        run_comp(1'b0, 0, 0, 1'b0, lat0);
        read_ch(5, q_hold);
        check("pre_stall_ch5", 32'(q_hold), 32'(exp_q(5)));
        run_comp(1'b0, 2, 3, 1'b1, lat1);
        check("stall_delay", 32'(lat1 - lat0), 32'd3);
        check("q_held_busy", 32'(q), 32'(q_hold));
        read_all("after_stall");

        // Reset in the middle of a run.
        model = 1'b1; comp = 1'b1;
        @(negedge clk);
        comp = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_q", 32'(q), 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen_done |= done;
        end
        check("midrun_no_done", 32'(seen_done), 32'd0);
        m_model = 1'b0;
        for (int c = 0; c < WIDTH; c++) m_acc[c] = 0;
        read_ch(0, qv);
        check("midrun_read0", 32'(qv), 32'd0);
        run_comp(1'b1, 0, 0, 1'b0, lat0);
        read_all("post_reset");

        // Synchronous clear.
        set = 1'b1;
        @(negedge clk);
        set = 1'b0;
        for (int c = 0; c < WIDTH; c++) m_acc[c] = 0;
        read_all("after_set");
        read_ch(20, qv);
        check("read_a20", 32'(qv), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
